// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage RV32I pipeline: load-use
// stalls, EX redirects, data-memory freeze, operand forwarding and event counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regWrite,
  input  logic             id_memToReg,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             ex_valid_r, ex_regwrite_r, ex_memtoreg_r, ex_use_rs1_r, ex_use_rs2_r;
  logic [4:0]       ex_rd_r, ex_rs1_r, ex_rs2_r;
  logic             mem_valid_r, mem_regwrite_r, mem_memtoreg_r;
  logic [4:0]       mem_rd_r;
  logic             wb_valid_r, wb_regwrite_r;
  logic [4:0]       wb_rd_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  logic             freeze_s, redirect_s, load_use_s, ex_load_s, src_match_s;
  logic             mem_src_s, wb_src_s;
  logic [1:0]       fwd_a_s, fwd_b_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) r = v;
    else    r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // A zero destination never forwards, so x0 writes are always invisible here.
  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [4:0] rs,
                                         input logic mem_src, input logic [4:0] mem_rd,
                                         input logic wb_src, input logic [4:0] wb_rd);
    logic [1:0] sel;
    if (use_rs && mem_src && (mem_rd == rs) && (mem_rd != 5'd0))
      sel = 2'b01;
    else if (use_rs && wb_src && (wb_rd == rs) && (wb_rd != 5'd0))
      sel = 2'b10;
    else
      sel = 2'b00;
    return sel;
  endfunction

  // Hazard detection and forwarding selection from tracker state and current inputs.
  always_comb begin
    freeze_s    = mem_req & ~mem_ready & ~reset;
    redirect_s  = ex_redirect & ~freeze_s & ~reset;
    ex_load_s   = ex_valid_r & ex_regwrite_r & ex_memtoreg_r & (ex_rd_r != 5'd0);
    src_match_s = (id_use_rs1 & (id_rs1 == ex_rd_r)) | (id_use_rs2 & (id_rs2 == ex_rd_r));
    load_use_s  = id_valid & ex_load_s & src_match_s & ~freeze_s & ~redirect_s & ~reset;
    mem_src_s   = mem_valid_r & mem_regwrite_r & ~mem_memtoreg_r;
    wb_src_s    = wb_valid_r & wb_regwrite_r;
    fwd_a_s     = fwd_sel(ex_valid_r & ex_use_rs1_r, ex_rs1_r, mem_src_s, mem_rd_r, wb_src_s, wb_rd_r);
    fwd_b_s     = fwd_sel(ex_valid_r & ex_use_rs2_r, ex_rs2_r, mem_src_s, mem_rd_r, wb_src_s, wb_rd_r);
  end

  // Pipeline control outputs; reset forces a flush/bubble, freeze silences the rest.
  always_comb begin
    stall_pc   = load_use_s;
    stall_ifid = load_use_s;
    bubble_ex  = reset | redirect_s | load_use_s;
    flush_ifid = reset | redirect_s;
    freeze     = freeze_s;
    if (reset) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end else begin
      fwd_a = fwd_a_s;
      fwd_b = fwd_b_s;
    end
    stall_cnt  = stall_cnt_r;
    flush_cnt  = flush_cnt_r;
  end

  // Shadow occupancy tracker and saturating counters, held while frozen.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid_r     <= 1'b0;
      ex_regwrite_r  <= 1'b0;
      ex_memtoreg_r  <= 1'b0;
      ex_use_rs1_r   <= 1'b0;
      ex_use_rs2_r   <= 1'b0;
      ex_rd_r        <= 5'd0;
      ex_rs1_r       <= 5'd0;
      ex_rs2_r       <= 5'd0;
      mem_valid_r    <= 1'b0;
      mem_regwrite_r <= 1'b0;
      mem_memtoreg_r <= 1'b0;
      mem_rd_r       <= 5'd0;
      wb_valid_r     <= 1'b0;
      wb_regwrite_r  <= 1'b0;
      wb_rd_r        <= 5'd0;
      stall_cnt_r    <= {CNT_W{1'b0}};
      flush_cnt_r    <= {CNT_W{1'b0}};
    end else if (!freeze_s) begin
      wb_valid_r     <= mem_valid_r;
      wb_regwrite_r  <= mem_regwrite_r;
      wb_rd_r        <= mem_rd_r;
      mem_valid_r    <= ex_valid_r;
      mem_regwrite_r <= ex_regwrite_r;
      mem_memtoreg_r <= ex_memtoreg_r;
      mem_rd_r       <= ex_rd_r;
      if (redirect_s || load_use_s) begin
        ex_valid_r    <= 1'b0;
        ex_regwrite_r <= 1'b0;
        ex_memtoreg_r <= 1'b0;
        ex_use_rs1_r  <= 1'b0;
        ex_use_rs2_r  <= 1'b0;
        ex_rd_r       <= 5'd0;
        ex_rs1_r      <= 5'd0;
        ex_rs2_r      <= 5'd0;
      end else begin
        ex_valid_r    <= id_valid;
        ex_regwrite_r <= id_regWrite;
        ex_memtoreg_r <= id_memToReg;
        ex_use_rs1_r  <= id_use_rs1;
        ex_use_rs2_r  <= id_use_rs2;
        ex_rd_r       <= id_rd;
        ex_rs1_r      <= id_rs1;
        ex_rs2_r      <= id_rs2;
      end
      if (load_use_s) stall_cnt_r <= sat_inc(stall_cnt_r);
      else            stall_cnt_r <= stall_cnt_r;
      if (redirect_s) flush_cnt_r <= sat_inc(flush_cnt_r);
      else            flush_cnt_r <= flush_cnt_r;
    end else begin
      stall_cnt_r <= stall_cnt_r;
      flush_cnt_r <= flush_cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-width instance and a 4-bit-counter
// instance share stimulus so saturation can be observed alongside normal counting.
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset, id_valid, id_use_rs1, id_use_rs2, id_regWrite, id_memToReg;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_redirect, mem_req, mem_ready;
  logic        stall_pc, stall_ifid, bubble_ex, flush_ifid, freeze;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic        stall_pc4, stall_ifid4, bubble_ex4, flush_ifid4, freeze4;
  logic [1:0]  fwd_a4, fwd_b4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  hazard_ctrl dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_memToReg(id_memToReg), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .bubble_ex(bubble_ex), .flush_ifid(flush_ifid), .freeze(freeze), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_memToReg(id_memToReg), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .stall_pc(stall_pc4), .stall_ifid(stall_ifid4),
    .bubble_ex(bubble_ex4), .flush_ifid(flush_ifid4), .freeze(freeze4), .fwd_a(fwd_a4),
    .fwd_b(fwd_b4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic m2r);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regWrite = rw; id_memToReg = m2r;
  endtask

  task automatic id_nop();
    id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    id_nop();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ex_redirect = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    id_nop();
    #2;
    chk("rst_freeze",  freeze,     32'd0);
    chk("rst_flush",   flush_ifid, 32'd1);
    chk("rst_bubble",  bubble_ex,  32'd1);
    chk("rst_stallpc", stall_pc,   32'd0);
    chk("rst_stallid", stall_ifid, 32'd0);
    chk("rst_fwd_a",   fwd_a,      32'd0);
    mem_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #2;
    chk("rst_stallcnt", stall_cnt,  32'd0);
    chk("rst_flushcnt", flush_cnt,  32'd0);
    chk("rst_rel_flush", flush_ifid, 32'd0);

    // lw x5 ; add x6,x5,x1
    id_set(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    #2 chk("lu_none_first", stall_pc, 32'd0);
    tick();
    id_set(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #2;
    chk("lu_stallpc", stall_pc,   32'd1);
    chk("lu_stallid", stall_ifid, 32'd1);
    chk("lu_bubble",  bubble_ex,  32'd1);
    chk("lu_noflush", flush_ifid, 32'd0);
    tick();
    #2;
    chk("lu_one_cycle", stall_pc,  32'd0);
    chk("lu_no_bubble", bubble_ex, 32'd0);
    tick();
    id_nop();
    #2;
    chk("lu_fwd_a_wb", fwd_a,     32'd2);
    chk("lu_fwd_b",    fwd_b,     32'd0);
    chk("lu_cnt",      stall_cnt, 32'd1);
    tick();

    // addi x3 ; sub x4,x3,x3
    id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    #2 chk("alu_nostall", stall_pc, 32'd0);
    tick();
    id_nop();
    #2;
    chk("alu_fwd_a_mem", fwd_a, 32'd1);
    chk("alu_fwd_b_mem", fwd_b, 32'd1);
    tick();

    // addi x8 ; nop ; add x9,x8,x0
    id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    id_nop();
    tick();
    id_set(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    id_nop();
    #2;
    chk("gap_fwd_a_wb", fwd_a, 32'd2);
    chk("gap_fwd_b_x0", fwd_b, 32'd0);
    tick();

    // addi x0 ; add x10,x0,x0
    id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    id_nop();
    #2;
    chk("x0_fwd_a", fwd_a, 32'd0);
    chk("x0_fwd_b", fwd_b, 32'd0);
    tick();

    // redirect with a pending load-use match
    do_reset();
    id_set(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    id_set(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    #2;
    chk("rd_flush",   flush_ifid, 32'd1);
    chk("rd_bubble",  bubble_ex,  32'd1);
    chk("rd_stallpc", stall_pc,   32'd0);
    chk("rd_stallid", stall_ifid, 32'd0);
    tick();
    ex_redirect = 1'b0;
    id_nop();
    #2;
    chk("rd_flushcnt", flush_cnt,  32'd1);
    chk("rd_stallcnt", stall_cnt,  32'd0);
    chk("rd_release",  flush_ifid, 32'd0);
    tick();

    // memory wait with a redirect held across the freeze
    id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    id_nop();
    mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("fz_freeze",  freeze,     32'd1);
      chk("fz_noflush", flush_ifid, 32'd0);
      chk("fz_nobub",   bubble_ex,  32'd0);
      chk("fz_fwd_a",   fwd_a,      32'd1);
      chk("fz_fwd_b",   fwd_b,      32'd1);
      tick();
    end
    mem_ready = 1'b1;
    #2;
    chk("fz_rel_freeze", freeze,     32'd0);
    chk("fz_rel_flush",  flush_ifid, 32'd1);
    chk("fz_rel_bubble", bubble_ex,  32'd1);
    chk("fz_rel_fwd_a",  fwd_a,      32'd1);
    tick();
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #2;
    chk("fz_flushcnt", flush_cnt, 32'd2);
    chk("fz_stallcnt", stall_cnt, 32'd0);

    // load-use seen during a freeze is re-evaluated on release
    id_set(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    id_set(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    mem_req = 1'b1; mem_ready = 1'b0;
    #2;
    chk("fzlu_nostall", stall_pc, 32'd0);
    chk("fzlu_freeze",  freeze,   32'd1);
    tick();
    mem_ready = 1'b1;
    #2 chk("fzlu_stall", stall_pc, 32'd1);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    id_nop();
    #2 chk("fzlu_cnt", stall_cnt, 32'd1);

    // saturation: lw x5,0(x5) repeated hazards every other cycle
    do_reset();
    id_set(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) tick();
    #2;
    chk("sat_cnt16", stall_cnt,  32'd20);
    chk("sat_cnt4",  stall_cnt4, 32'd15);
    tick();
    #2 chk("mf_pre_stall", stall_pc, 32'd1);

    // reset asserted mid-freeze
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    chk("mf_freeze",  freeze,   32'd1);
    chk("mf_nostall", stall_pc, 32'd0);
    reset = 1'b1;
    #1;
    chk("mf_rst_freeze", freeze,     32'd0);
    chk("mf_rst_flush",  flush_ifid, 32'd1);
    chk("mf_rst_bubble", bubble_ex,  32'd1);
    tick();
    reset = 1'b0;
    #2;
    chk("mf_freeze_again", freeze,     32'd1);
    chk("mf_stallcnt",     stall_cnt,  32'd0);
    chk("mf_stallcnt4",    stall_cnt4, 32'd0);
    chk("mf_flushcnt",     flush_cnt,  32'd0);
    chk("mf_fwd_a",        fwd_a,      32'd0);
    chk("mf_fwd_b",        fwd_b,      32'd0);
    mem_req = 1'b0;
    #1;
    chk("mf_unfreeze",   freeze,   32'd0);
    chk("mf_ex_invalid", stall_pc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
